logistic_iter_ctrl: RTL and testbench

Epoch scheduler for the logistic-map sound generator. Every ITER_LEN clocks it advances the logistic map x' = r*x*(1-x) once for each of N_OSC oscillator slots. It time-shares one external multiplier through a req/ack handshake and writes each new x to the oscillator bank. It also sweeps the base growth rate r upward by R_INC per epoch, wrapping at the top of the range.

---
 rtl/logistic_iter_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_logistic_iter_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logistic_iter_ctrl.sv
`default_nettype none
// =============================================================================
// logistic_iter_ctrl : per-epoch logistic-map update of N_OSC oscillator slots
// Rev 1.0
// =============================================================================
module logistic_iter_ctrl #(
  parameter int N_OSC     = 8,
  parameter int ITER_LEN  = 15361,
  parameter int FRAC      = 16,
  parameter int R_INC     = 2,
  parameter int R_START   = 3 << FRAC,
  parameter int R_SPREAD  = 1 << (FRAC - 6),
  parameter int SEED_BASE = 1 << (FRAC - 1),
  parameter int SEED_STEP = 1 << (FRAC - 4),
  localparam int IW       = $clog2((N_OSC > 1) ? N_OSC : 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              mul_req,
  output logic [FRAC+1:0]   mul_a,
  output logic [FRAC+1:0]   mul_b,
  input  logic              mul_ack,
  input  logic [2*FRAC+3:0] mul_p,
  output logic              x_wr_en,
  output logic [IW-1:0]     x_wr_idx,
  output logic [FRAC-1:0]   x_wr_data,
  output logic [FRAC+1:0]   r_base,
  output logic              epoch_done,
  output logic              busy,
  output logic              overrun
);

  localparam int TW    = $clog2(ITER_LEN);
  localparam int PW    = 2*FRAC + 4;
  localparam int RW    = FRAC + 2;
  localparam int DEPTH = 1 << IW;

  localparam logic [TW-1:0]   TICK_LAST  = TW'(ITER_LEN - 1);
  localparam logic [IW-1:0]   IDX_LAST   = IW'(N_OSC - 1);
  localparam logic [RW-1:0]   ONE_Q      = {2'b01, {FRAC{1'b0}}};
  localparam logic [RW-1:0]   R_RESET    = RW'(R_START);
  localparam logic [PW-1:0]   R_MAX      = {{(PW-RW){1'b0}}, {RW{1'b1}}};
  localparam logic [PW-1:0]   SPREAD_TOP = PW'((N_OSC - 1) * R_SPREAD);
  localparam logic [FRAC-1:0] X_MIN      = FRAC'(1);
  localparam logic [FRAC-1:0] X_MAX      = {FRAC{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL1  = 3'd1,
    S_MUL2  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t          state;
  logic [TW-1:0]   tick;
  logic [IW-1:0]   idx;
  logic [FRAC-1:0] x_mem [DEPTH];

  logic            epoch_start;
  logic            xfer;
  logic [FRAC+3:0] p_hi;
  logic [FRAC-1:0] t_val;
  logic [FRAC-1:0] y_val;
  logic [RW-1:0]   r_slot;
  logic [PW-1:0]   r_stepped;
  logic            r_wrap;
  logic [IW-1:0]   idx_next;
  logic            p_lo_unused;

  // Seeds wrap modulo 2^FRAC; zero is the map's fixed point so it is bumped to 1.
  function automatic logic [FRAC-1:0] seed(input int k);
    logic [FRAC-1:0] s;
    s = FRAC'(SEED_BASE + k * SEED_STEP);
    if (s == '0) s = X_MIN;
    return s;
  endfunction

  function automatic logic [RW-1:0] ext(input logic [FRAC-1:0] v);
    return {2'b00, v};
  endfunction

  assign epoch_start = run && (tick == TICK_LAST);
  assign xfer        = mul_req && mul_ack;
  assign p_hi        = mul_p[PW-1:FRAC];
  assign p_lo_unused = ^mul_p[FRAC-1:0];
  assign t_val       = p_hi[FRAC-1:0];
  assign r_slot      = r_base + RW'(int'(idx) * R_SPREAD);
  assign r_stepped   = PW'(r_base) + PW'(R_INC);
  assign r_wrap      = (r_stepped + SPREAD_TOP) > R_MAX;
  assign idx_next    = idx + IW'(1);

  always_comb begin
    y_val = p_hi[FRAC-1:0];
    if (|p_hi[FRAC+3:FRAC]) begin
      y_val = X_MAX;
    end else if (p_hi[FRAC-1:0] == '0) begin
      y_val = X_MIN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick <= '0;
    end else if (run) begin
      tick <= (tick == TICK_LAST) ? '0 : tick + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      mul_req    <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      x_wr_en    <= 1'b0;
      x_wr_idx   <= '0;
      x_wr_data  <= '0;
      r_base     <= R_RESET;
      epoch_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        x_mem[k] <= seed(k);
      end
    end else begin
      x_wr_en    <= 1'b0;
      epoch_done <= 1'b0;
      // A tick that lands on a running epoch is dropped, only flagged.
      if (epoch_start && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (epoch_start) begin
            state   <= S_MUL1;
            idx     <= '0;
            busy    <= 1'b1;
            mul_req <= 1'b1;
            mul_a   <= ext(x_mem[0]);
            mul_b   <= ONE_Q - ext(x_mem[0]);
          end
        end
        S_MUL1: begin
          if (xfer) begin
            state <= S_MUL2;
            mul_a <= r_slot;
            mul_b <= ext(t_val);
          end
        end
        S_MUL2: begin
          if (xfer) begin
            state      <= S_WRITE;
            mul_req    <= 1'b0;
            x_wr_en    <= 1'b1;
            x_wr_idx   <= idx;
            x_wr_data  <= y_val;
            x_mem[idx] <= y_val;
          end
        end
        S_WRITE: begin
          if (idx == IDX_LAST) begin
            state      <= S_DONE;
            epoch_done <= 1'b1;
          end else begin
            state   <= S_MUL1;
            idx     <= idx_next;
            mul_req <= 1'b1;
            mul_a   <= ext(x_mem[idx_next]);
            mul_b   <= ONE_Q - ext(x_mem[idx_next]);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          // Wrap once the highest slot's rate would leave the Q2.FRAC range.
          r_base <= r_wrap ? R_RESET : r_stepped[RW-1:0];
        end
        default: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          mul_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_logistic_iter_ctrl.sv
`default_nettype none
// =============================================================================
// tb_logistic_iter_ctrl : directed + randomized-ack bench with reference model
// =============================================================================
module tb_logistic_iter_ctrl;

  localparam int FRAC = 16;
  localparam int RW   = FRAC + 2;
  localparam int PW   = 2*FRAC + 4;

  logic clk;
  logic rst_a, rst_b, run_a, run_b;
  logic ack_a, ack_force;
  logic ack_hi;

  logic req_a, wr_a, done_a, busy_a, ovr_a;
  logic [RW-1:0] a_a, b_a, rb_a;
  logic [PW-1:0] p_a;
  logic [1:0] widx_a;
  logic [FRAC-1:0] wdat_a;

  logic req_b, wr_b, done_b, busy_b, ovr_b;
  logic [RW-1:0] a_b, b_b, rb_b;
  logic [PW-1:0] p_b;
  logic [0:0] widx_b;
  logic [FRAC-1:0] wdat_b;

  logic req_c, wr_c, done_c, busy_c, ovr_c;
  logic [RW-1:0] a_c, b_c, rb_c;
  logic [PW-1:0] p_c;
  logic [0:0] widx_c;
  logic [FRAC-1:0] wdat_c;

  logic req_d, wr_d, done_d, busy_d, ovr_d;
  logic [RW-1:0] a_d, b_d, rb_d;
  logic [PW-1:0] p_d;
  logic [0:0] widx_d;
  logic [FRAC-1:0] wdat_d;

  assign p_a = PW'(a_a) * PW'(b_a);
  assign p_b = PW'(a_b) * PW'(b_b);
  assign p_c = PW'(a_c) * PW'(b_c);
  assign p_d = PW'(a_d) * PW'(b_d);

  logistic_iter_ctrl #(.N_OSC(4), .ITER_LEN(64)) u_a (
    .clk(clk), .reset(rst_a), .run(run_a), .mul_req(req_a), .mul_a(a_a), .mul_b(b_a),
    .mul_ack(ack_a), .mul_p(p_a), .x_wr_en(wr_a), .x_wr_idx(widx_a), .x_wr_data(wdat_a),
    .r_base(rb_a), .epoch_done(done_a), .busy(busy_a), .overrun(ovr_a));

  logistic_iter_ctrl #(.N_OSC(1), .ITER_LEN(64), .R_SPREAD(0)) u_b (
    .clk(clk), .reset(rst_b), .run(run_b), .mul_req(req_b), .mul_a(a_b), .mul_b(b_b),
    .mul_ack(ack_hi), .mul_p(p_b), .x_wr_en(wr_b), .x_wr_idx(widx_b), .x_wr_data(wdat_b),
    .r_base(rb_b), .epoch_done(done_b), .busy(busy_b), .overrun(ovr_b));

  logistic_iter_ctrl #(.N_OSC(2), .ITER_LEN(4)) u_c (
    .clk(clk), .reset(rst_b), .run(run_b), .mul_req(req_c), .mul_a(a_c), .mul_b(b_c),
    .mul_ack(ack_hi), .mul_p(p_c), .x_wr_en(wr_c), .x_wr_idx(widx_c), .x_wr_data(wdat_c),
    .r_base(rb_c), .epoch_done(done_c), .busy(busy_c), .overrun(ovr_c));

  logistic_iter_ctrl #(.N_OSC(1), .ITER_LEN(16), .R_START('h3FF00), .R_INC('h80),
                       .SEED_BASE('hFFFF)) u_d (
    .clk(clk), .reset(rst_b), .run(run_b), .mul_req(req_d), .mul_a(a_d), .mul_b(b_d),
    .mul_ack(ack_hi), .mul_p(p_d), .x_wr_en(wr_d), .x_wr_idx(widx_d), .x_wr_data(wdat_d),
    .r_base(rb_d), .epoch_done(done_d), .busy(busy_d), .overrun(ovr_d));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic for the logistic step in Q0.16 / Q2.16.
  function automatic longint t_ref(input longint x);
    return (x * (65536 - x)) >> 16;
  endfunction

  function automatic longint y_ref(input longint x, input longint r);
    longint y;
    y = (r * t_ref(x)) >> 16;
    if (y > 65535) y = 65535;
    if (y == 0) y = 1;
    return y;
  endfunction

  function automatic longint seed_a(input int k);
    longint s;
    s = ('h8000 + k * 'h1000) % 65536;
    if (s == 0) s = 1;
    return s;
  endfunction

  longint mx [4];
  longint mr;
  int     widx_m, phase_a, done_cnt_a, wr_cnt_a, done_cnt_c;
  bit     prev_req_m, prev_xfer_m;
  logic [RW-1:0] prev_a, prev_b;

  // Multiplier responder for u_a: random 0..4 cycle ack latency per request.
  initial begin
    int  cnt;
    int  dly;
    bit  fresh;
    cnt = 0; dly = 0; fresh = 1'b1; ack_a = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (ack_force) begin
        ack_a = 1'b1; fresh = 1'b1;
      end else if (rst_a || !req_a) begin
        ack_a = 1'b0; fresh = 1'b1;
      end else begin
        if (fresh) begin dly = $urandom_range(0, 4); cnt = 0; fresh = 1'b0; end
        ack_a = (cnt >= dly);
        cnt++;
        if (ack_a) fresh = 1'b1;
      end
    end
  end

  // Scoreboard for u_a, sampled after inputs for the coming edge are settled.
  initial begin
    bit     xfer;
    longint exp;
    done_cnt_a = 0; wr_cnt_a = 0; done_cnt_c = 0;
    forever begin
      @(negedge clk); #2;
      if (done_c) done_cnt_c++;
      if (rst_a) begin
        for (int k = 0; k < 4; k++) mx[k] = seed_a(k);
        mr = 'h30000; widx_m = 0; phase_a = 0;
        prev_req_m = 1'b0; prev_xfer_m = 1'b0;
      end else begin
        xfer = req_a && ack_a;
        if (req_a && prev_req_m && !prev_xfer_m) begin
          check("a_stable", a_a, prev_a);
          check("b_stable", b_a, prev_b);
        end
        if (xfer && widx_m < 4) begin
          if (phase_a == 0) begin
            check("mul1_a", a_a, mx[widx_m]);
            check("mul1_b", b_a, 65536 - mx[widx_m]);
            phase_a = 1;
          end else begin
            check("mul2_a", a_a, mr + widx_m * 'h400);
            check("mul2_b", b_a, t_ref(mx[widx_m]));
            phase_a = 0;
          end
        end
        if (wr_a) begin
          check("wr_idx", widx_a, widx_m);
          if (widx_m < 4) begin
            exp = y_ref(mx[widx_m], mr + widx_m * 'h400);
            check("wr_data", wdat_a, exp);
            mx[widx_m] = exp;
          end
          widx_m++; wr_cnt_a++;
        end
        if (done_a) begin
          check("done_slots", widx_m, 4);
          widx_m = 0;
          mr = mr + 2;
          if (mr + 3 * 'h400 > 'h3FFFF) mr = 'h30000;
          done_cnt_a++;
        end
        prev_req_m = req_a; prev_xfer_m = xfer; prev_a = a_a; prev_b = b_a;
      end
    end
  end

  initial begin
    int n;
    int d0;
    bit quiet;
    rst_a = 1'b1; rst_b = 1'b1; run_a = 1'b1; run_b = 1'b1;
    ack_force = 1'b0; ack_hi = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_rbase_b", rb_b, 'h30000);
    check("rst_req_b", req_b, 0);
    check("rst_wr_b", wr_b, 0);
    check("rst_done_b", done_b, 0);
    check("rst_busy_b", busy_b, 0);
    check("rst_ovr_b", ovr_b, 0);
    check("rst_rbase_d", rb_d, 'h3FF00);
    rst_a = 1'b0; rst_b = 1'b0;                    // cycle 0
    repeat (4) @(negedge clk);                     // cycle 4
    check("c_mul1_a0", a_c, 'h8000);
    check("c_mul1_b0", b_c, 'h8000);
    repeat (2) @(negedge clk);                     // cycle 6
    check("c_wr0", {wr_c, widx_c, wdat_c}, {1'b1, 1'b0, 16'hC000});
    @(negedge clk);                                // cycle 7
    check("c_mul1_a1", a_c, 'h9000);
    check("c_mul1_b1", b_c, 'h7000);
    check("c_ovr_before", ovr_c, 0);
    @(negedge clk);                                // cycle 8
    check("c_ovr_set", ovr_c, 1);
    check("c_busy8", busy_c, 1);
    @(negedge clk);                                // cycle 9
    check("c_wr1_idx", widx_c, 1);
    check("c_wr1_data", wdat_c, y_ref('h9000, 'h30400));
    @(negedge clk);                                // cycle 10
    check("c_done", done_c, 1);
    @(negedge clk);                                // cycle 11
    check("c_idle11", busy_c, 0);
    @(negedge clk);                                // cycle 12
    check("c_restart", {busy_c, req_c}, 2'b11);
    check("c_mul1_a_upd", a_c, 'hC000);
    repeat (6) @(negedge clk);                     // cycle 18
    check("d_clamp", {wr_d, wdat_d}, {1'b1, 16'h0001});
    repeat (2) @(negedge clk);                     // cycle 20
    check("d_rstep", rb_d, 'h3FF80);
    repeat (16) @(negedge clk);                    // cycle 36
    check("d_rwrap", rb_d, 'h3FF00);
    repeat (27) @(negedge clk);                    // cycle 63
    check("b_idle63", {busy_b, req_b}, 2'b00);
    @(negedge clk);                                // cycle 64
    check("b_mul1", {req_b, a_b, b_b}, {1'b1, 18'h08000, 18'h08000});
    @(negedge clk);                                // cycle 65
    check("b_mul2", {req_b, a_b, b_b}, {1'b1, 18'h30000, 18'h04000});
    @(negedge clk);                                // cycle 66
    check("b_write", {wr_b, wdat_b}, {1'b1, 16'hC000});
    @(negedge clk);                                // cycle 67
    check("b_done", {done_b, req_b}, 2'b10);
    @(negedge clk);                                // cycle 68
    check("b_rbase", rb_b, 'h30002);
    check("b_idle68", {busy_b, done_b}, 2'b00);
    check("c_epochs", done_cnt_c, 8);

    repeat (600) @(negedge clk);

    // run=0 while an epoch is in flight: it completes, then nothing starts.
    for (n = 0; n < 200 && !busy_a; n++) @(negedge clk);
    check("a_wait_busy", busy_a, 1);
    d0 = done_cnt_a;
    run_a = 1'b0;
    for (n = 0; n < 200 && busy_a; n++) @(negedge clk);
    check("a_inflight_done", done_cnt_a, d0 + 1);
    quiet = 1'b1;
    repeat (150) begin @(negedge clk); if (busy_a) quiet = 1'b0; end
    check("a_hold_quiet", quiet, 1);
    run_a = 1'b1;
    repeat (300) @(negedge clk);

    // Reset while waiting in MUL2, then a stray ack with no request.
    for (n = 0; n < 300 && !(phase_a == 1 && req_a); n++) @(negedge clk);
    check("a_wait_mul2", phase_a == 1 && req_a, 1);
    rst_a = 1'b1;
    @(negedge clk);
    check("a_rst_req", req_a, 0);
    check("a_rst_state", {busy_a, wr_a, done_a, ovr_a}, 4'b0000);
    check("a_rst_rbase", rb_a, 'h30000);
    ack_force = 1'b1; rst_a = 1'b0; run_a = 1'b0;
    quiet = 1'b1;
    repeat (10) begin @(negedge clk); if (busy_a || wr_a || req_a) quiet = 1'b0; end
    check("a_late_ack", quiet, 1);
    ack_force = 1'b0; run_a = 1'b1;
    for (n = 0; n < 200 && !busy_a; n++) @(negedge clk);
    check("a_first_tick", n, 64);
    repeat (400) @(negedge clk);
    check("a_overrun", ovr_a, 0);
    check("a_progress", wr_cnt_a > 40, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
